fpu_arbiter: RTL and testbench
==============================

# fpu_arbiter

Shared-FPU responder that lets up to NCLIENT requesters (sqrt, matrix, and filter-update engines) time-share one double-precision `fpu` instance. Each client issues operations over a simple valid/ack request port and receives a one-cycle response pulse. The arbiter drives the FPU's level-sensitive enable/op/operand interface and captures the result. It runs entirely on the rising edge of clk; no negedge logic.

## Interface

Parameters:

- NCLIENT, 4: number of client ports, 2..8.
- EN_HOLD, 7: cycles fpu_en is held high per operation, 1..15.
- TIMEOUT, 64: maximum WAIT cycles before an error response, 1..255. Used only with FPU_ARB_TIMEOUT_EN.

Ports:

- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  NCLIENT  per-client request valid.
- req_op  in  3*NCLIENT  FPU opcode per client, slice i at [3i+2:3i]; 000 add, 001 sub, 010 mul, 011 div.
- req_opa  in  64*NCLIENT  operand A per client.
- req_opb  in  64*NCLIENT  operand B per client.
- req_ack  out  NCLIENT  one-hot, one-cycle grant pulse.
- rsp_valid  out  NCLIENT  one-hot, one-cycle response pulse.
- rsp_data  out  64  result. Valid only while rsp_valid is nonzero.
- rsp_err  out  1  high with rsp_valid when the response is a timeout.
- busy  out  1  high in any state other than S_IDLE.
- fpu_en  out  1  FPU enable.
- fpu_op  out  3  FPU opcode.
- fpu_opa  out  64  FPU operand A.
- fpu_opb  out  64  FPU operand B.
- fpu_rmode  out  2  constant 2'b00 (round to nearest even).
- fpu_out  in  64  FPU result.
- fpu_ready  in  1  FPU result ready.

## Operation

- States:
  - S_IDLE
  - S_ISSUE: fpu_en high, hold counter running.
  - S_WAIT: waiting for fpu_ready.
- S_IDLE:
  - When any req_valid is high, select client g by round-robin, starting search at last_grant+1 modulo NCLIENT.
  - Register req_ack[g]=1 and latch op/opa/opb of client g into fpu_op/fpu_opa/fpu_opb.
  - Set last_grant=g, load hold_cnt=EN_HOLD-1, set fpu_en=1, go to S_ISSUE.
  - With no requests, stay in S_IDLE with all outputs quiescent.
- S_ISSUE:
  - req_ack returns to 0.
  - fpu_en stays high while hold_cnt decrements.
  - When hold_cnt==0: fpu_en=0, go to S_WAIT.
  - fpu_ready is ignored in S_ISSUE; this masks a stale ready from the previous operation.
- S_WAIT:
  - On fpu_ready=1: rsp_data<=fpu_out, rsp_valid[g]<=1, go to S_IDLE.
- Operands and opcode on the fpu_* outputs stay constant from grant until the response. They change only at the next grant.
- Client rules:
  - Hold req_valid and operands stable until req_ack is seen.
  - Keeping req_valid high after the ack means a new request.
  - A client may deassert req_valid before ack; no grant then occurs for it.
- rsp_valid and rsp_err are registered pulses exactly one cycle wide. rsp_data holds its value until the next response.
- Reset values: req_ack=0, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0, fpu_en=0, fpu_op=0, fpu_opa=0, fpu_opb=0, last_grant=NCLIENT-1 (client 0 has first priority), state S_IDLE.
- Reset mid-operation: the in-flight request is dropped with no response. fpu_en is low in the cycle after rst is sampled.
- Out-of-range opcodes (1xx) are forwarded unchanged. The FPU's behaviour defines the result.

## Timing

- Request sampled in S_IDLE at edge 0:
  - req_ack and fpu_en are high in cycle 1.
  - fpu_en is high for cycles 1..EN_HOLD.
  - S_WAIT starts in cycle EN_HOLD+1.
- fpu_ready is first sampled high at edge k ≥ EN_HOLD+1:
  - rsp_valid is high in cycle k+1.
  - The arbiter is in S_IDLE in cycle k+1 and can grant again at that edge (ack in cycle k+2).
- Minimum issue-to-issue spacing: EN_HOLD+2 cycles.
- fpu_ready high in the first S_WAIT cycle gives the minimum latency: ack cycle to rsp_valid = EN_HOLD+1 cycles.
- Fairness: with all clients requesting continuously, each client is granted once per NCLIENT operations.

## Configuration

- FPU_ARB_TIMEOUT_EN defined:
  - An 8-bit wait_cnt is cleared on entry to S_WAIT and increments each S_WAIT cycle without fpu_ready.
  - When wait_cnt reaches TIMEOUT-1 without fpu_ready: rsp_data<=64'h7FF8000000000000 (qNaN), rsp_err<=1, rsp_valid[g]<=1, go to S_IDLE.
  - fpu_ready and expiry in the same cycle: the real result wins, rsp_err=0.
- FPU_ARB_TIMEOUT_EN undefined:
  - No wait counter.
  - rsp_err is tied 0.
  - S_WAIT waits indefinitely.

## Test plan

- Single request, client 1, op=010, opa=0x4000000000000000 (2.0), opb=0x4008000000000000 (3.0), FPU model ready 3 cycles after fpu_en falls:
  - req_ack[1] in cycle 1.
  - fpu_en in cycles 1..7.
  - rsp_valid=4'b0010 with rsp_data=0x4018000000000000 (6.0) in cycle 11.
- All four clients request at edge 0:
  - Grants in order 0,1,2,3.
  - Acks spaced ≥EN_HOLD+2 cycles apart.
  - Each rsp_valid matches its client's own operands.
- Stale ready: FPU model holds fpu_ready=1 throughout S_ISSUE. The response appears only after S_WAIT entry, carrying the new result.
- rst asserted in S_WAIT, then a new request from client 2 after reset:
  - No rsp_valid for the dropped request.
  - fpu_en=0 the cycle after reset.
  - Client 0 keeps priority if it also requests.
- With FPU_ARB_TIMEOUT_EN, TIMEOUT=16, FPU never raises ready:
  - rsp_valid plus rsp_err=1 and rsp_data=0x7FF8000000000000 exactly 16 cycles after S_WAIT entry.
- Without the macro, same stimulus: busy stays high and there is no response.

Source files
------------

// File: rtl/fpu_arbiter_if.sv
// Client request/response and FPU-side signal bundle for fpu_arbiter.
// The arbiter uses the slave modport; clients and the FPU model use master.
interface fpu_arbiter_if #(
  parameter int NCLIENT = 4
);
  logic [NCLIENT-1:0]    req_valid;
  logic [3*NCLIENT-1:0]  req_op;
  logic [64*NCLIENT-1:0] req_opa;
  logic [64*NCLIENT-1:0] req_opb;
  logic [NCLIENT-1:0]    req_ack;
  logic [NCLIENT-1:0]    rsp_valid;
  logic [63:0]           rsp_data;
  logic                  rsp_err;
  logic                  busy;
  logic                  fpu_en;
  logic [2:0]            fpu_op;
  logic [63:0]           fpu_opa;
  logic [63:0]           fpu_opb;
  logic [1:0]            fpu_rmode;
  logic [63:0]           fpu_out;
  logic                  fpu_ready;
  logic [1:0]            dbg_state;

  // Handshake: a client holds req_valid and its operands until it sees its
  // one-cycle req_ack; rsp_valid is a one-cycle pulse to the granted client.
  modport slave (
    input  req_valid, req_op, req_opa, req_opb, fpu_out, fpu_ready,
    output req_ack, rsp_valid, rsp_data, rsp_err, busy,
           fpu_en, fpu_op, fpu_opa, fpu_opb, fpu_rmode, dbg_state
  );

  modport master (
    output req_valid, req_op, req_opa, req_opb, fpu_out, fpu_ready,
    input  req_ack, rsp_valid, rsp_data, rsp_err, busy,
           fpu_en, fpu_op, fpu_opa, fpu_opb, fpu_rmode, dbg_state
  );
endinterface

// File: rtl/fpu_arbiter.sv
// Round-robin arbiter time-sharing one FPU between NCLIENT requesters.
// Optional wait timeout with qNaN error response: define FPU_ARB_TIMEOUT_EN.
module fpu_arbiter #(
  parameter int NCLIENT = 4,
  parameter int EN_HOLD = 7,
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst,
  fpu_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(NCLIENT);
  localparam logic [NCLIENT-1:0] ONE_HOT0 = {{(NCLIENT-1){1'b0}}, 1'b1};

  if (NCLIENT < 2 || NCLIENT > 8 || EN_HOLD < 1 || EN_HOLD > 15 ||
      TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_params
    $error("fpu_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [IDX_W-1:0]   r_last_grant;
  logic [IDX_W-1:0]   r_gnt_idx;
  logic [3:0]         r_hold_cnt;
  logic [NCLIENT-1:0] r_ack;
  logic [NCLIENT-1:0] r_rsp_valid;
  logic [63:0]        r_rsp_data;
  logic [2:0]         r_fpu_op;
  logic [63:0]        r_fpu_opa;
  logic [63:0]        r_fpu_opb;

  logic               w_found;
  logic [IDX_W-1:0]   w_idx;
  logic [IDX_W-1:0]   w_try;
  logic               w_grant;
  logic               w_done;
  logic               w_expire;
  logic               w_fpu_en;
  logic               w_busy;

  logic [2:0]  w_op_arr  [NCLIENT];
  logic [63:0] w_opa_arr [NCLIENT];
  logic [63:0] w_opb_arr [NCLIENT];

  for (genvar gi = 0; gi < NCLIENT; gi++) begin : g_unpack
    assign w_op_arr[gi]  = bus.req_op[3*gi +: 3];
    assign w_opa_arr[gi] = bus.req_opa[64*gi +: 64];
    assign w_opb_arr[gi] = bus.req_opb[64*gi +: 64];
  end

  // Search starts one past the last grant so every requester is reached
  // within NCLIENT grants.
  always_comb begin : rr_select
    w_found = 1'b0;
    w_idx   = '0;
    w_try   = r_last_grant;
    for (int k = 0; k < NCLIENT; k++) begin
      w_try = (w_try == IDX_W'(NCLIENT - 1)) ? '0 : w_try + IDX_W'(1);
      if (!w_found && bus.req_valid[w_try]) begin
        w_found = 1'b1;
        w_idx   = w_try;
      end
    end
  end

`ifdef FPU_ARB_TIMEOUT_EN
  localparam logic [7:0]  TO_LAST = 8'(TIMEOUT - 1);
  localparam logic [63:0] QNAN    = 64'h7FF8_0000_0000_0000;
  logic [7:0] r_wait_cnt;
  logic       r_rsp_err;
  assign w_expire = (r_state == S_WAIT) && !bus.fpu_ready && (r_wait_cnt == TO_LAST);
  assign bus.rsp_err = r_rsp_err;
`else
  assign w_expire    = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin : state_reg
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin : next_state
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_next_state = S_ISSUE;
      S_ISSUE: if (r_hold_cnt == 4'd0) w_next_state = S_WAIT;
      S_WAIT:  if (bus.fpu_ready || w_expire) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // fpu_ready only counts in S_WAIT, which hides a ready left over from the
  // previous operation while the new one is still being issued.
  always_comb begin : output_decode
    w_grant  = 1'b0;
    w_done   = 1'b0;
    w_fpu_en = 1'b0;
    w_busy   = 1'b0;
    case (r_state)
      S_IDLE:  w_grant = w_found;
      S_ISSUE: begin
        w_fpu_en = 1'b1;
        w_busy   = 1'b1;
      end
      S_WAIT:  begin
        w_busy = 1'b1;
        w_done = bus.fpu_ready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin : datapath
    if (rst) begin
      r_last_grant <= IDX_W'(NCLIENT - 1);
      r_gnt_idx    <= '0;
      r_hold_cnt   <= 4'd0;
      r_ack        <= '0;
      r_rsp_valid  <= '0;
      r_rsp_data   <= 64'd0;
      r_fpu_op     <= 3'd0;
      r_fpu_opa    <= 64'd0;
      r_fpu_opb    <= 64'd0;
    end else begin
      r_ack       <= '0;
      r_rsp_valid <= '0;
      if (w_grant) begin
        r_ack        <= ONE_HOT0 << w_idx;
        r_gnt_idx    <= w_idx;
        r_last_grant <= w_idx;
        r_fpu_op     <= w_op_arr[w_idx];
        r_fpu_opa    <= w_opa_arr[w_idx];
        r_fpu_opb    <= w_opb_arr[w_idx];
        r_hold_cnt   <= 4'(EN_HOLD - 1);
      end else if (r_state == S_ISSUE && r_hold_cnt != 4'd0) begin
        r_hold_cnt <= r_hold_cnt - 4'd1;
      end
      if (w_done) begin
        r_rsp_data  <= bus.fpu_out;
        r_rsp_valid <= ONE_HOT0 << r_gnt_idx;
      end
`ifdef FPU_ARB_TIMEOUT_EN
      if (w_expire) begin
        r_rsp_data  <= QNAN;
        r_rsp_valid <= ONE_HOT0 << r_gnt_idx;
      end
`endif
    end
  end

`ifdef FPU_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin : timeout_reg
    if (rst) begin
      r_wait_cnt <= 8'd0;
      r_rsp_err  <= 1'b0;
    end else begin
      r_rsp_err <= w_expire;
      if (r_state != S_WAIT)   r_wait_cnt <= 8'd0;
      else if (!bus.fpu_ready) r_wait_cnt <= r_wait_cnt + 8'd1;
    end
  end
`endif

  assign bus.req_ack   = r_ack;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.busy      = w_busy;
  assign bus.fpu_en    = w_fpu_en;
  assign bus.fpu_op    = r_fpu_op;
  assign bus.fpu_opa   = r_fpu_opa;
  assign bus.fpu_opb   = r_fpu_opb;
  assign bus.fpu_rmode = 2'b00;
  assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_fpu_arbiter.sv
// Directed bench for fpu_arbiter: vector table of single operations plus
// sequences for round-robin bursts, stale ready, reset drop and timeout.
module tb_fpu_arbiter;
  localparam int NC = 4;
  localparam int EH = 7;
  localparam int TO = 16;

  localparam logic [63:0] F_0P25 = 64'h3FD0_0000_0000_0000;
  localparam logic [63:0] F_1    = 64'h3FF0_0000_0000_0000;
  localparam logic [63:0] F_2    = 64'h4000_0000_0000_0000;
  localparam logic [63:0] F_3    = 64'h4008_0000_0000_0000;
  localparam logic [63:0] F_4    = 64'h4010_0000_0000_0000;
  localparam logic [63:0] F_5    = 64'h4014_0000_0000_0000;
  localparam logic [63:0] F_6    = 64'h4018_0000_0000_0000;
  localparam logic [63:0] F_8    = 64'h4020_0000_0000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fpu_arbiter_if #(.NCLIENT(NC)) bus ();

  fpu_arbiter #(.NCLIENT(NC), .EN_HOLD(EH), .TIMEOUT(TO)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // FPU model: real arithmetic for 0xx opcodes, XOR for anything else.
  function automatic logic [63:0] fpu_model(input logic [2:0] op, input logic [63:0] a,
                                            input logic [63:0] b);
    real ra, rb;
    ra = $bitstoreal(a);
    rb = $bitstoreal(b);
    case (op)
      3'b000:  return $realtobits(ra + rb);
      3'b001:  return $realtobits(ra - rb);
      3'b010:  return $realtobits(ra * rb);
      3'b011:  return $realtobits(ra / rb);
      default: return a ^ b;
    endcase
  endfunction

  assign bus.fpu_out = fpu_model(bus.fpu_op, bus.fpu_opa, bus.fpu_opb);

  typedef struct {
    int          client;
    logic [2:0]  op;
    logic [63:0] opa;
    logic [63:0] opb;
    int          delay;
    int          exp_lat;
    logic [63:0] exp_data;
  } vec_t;

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;
  int rdy_mode = 0;   // 0: pulse rdy_delay cycles after fpu_en falls, 1: always, 2: never
  int rdy_delay = 1;
  int since    = 1000;

  logic [63:0] exp_q[$];
  logic [3:0]  exp_cl_q[$];
  int          grant_exp_q[$];
  logic [63:0] cl_exp[NC];
  vec_t        vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance one cycle and update the FPU ready model just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.fpu_en) since = 0;
    else if (since < 1000) since++;
    case (rdy_mode)
      0:       bus.fpu_ready = (since == rdy_delay);
      1:       bus.fpu_ready = 1'b1;
      default: bus.fpu_ready = 1'b0;
    endcase
  endtask

  task automatic set_req(input int c, input logic [2:0] op, input logic [63:0] a,
                         input logic [63:0] b);
    bus.req_op[3*c +: 3]   = op;
    bus.req_opa[64*c +: 64] = a;
    bus.req_opb[64*c +: 64] = b;
  endtask

  task automatic wait_ack(output logic got, output int t_ack);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.req_ack != '0) begin
        got = 1'b1;
        break;
      end
    end
    t_ack = cyc;
    check("ack_seen", got, 1'b1);
    bus.req_valid = bus.req_valid & ~bus.req_ack;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    logic got;
    logic early;
    int   t0, t_ack, en_cnt;
    rdy_mode  = 0;
    rdy_delay = v.delay;
    set_req(v.client, v.op, v.opa, v.opb);
    bus.req_valid = '0;
    bus.req_valid[v.client] = 1'b1;
    t0 = cyc;
    wait_ack(got, t_ack);
    if (!got) begin
      bus.req_valid = '0;
      return;
    end
    check("vec_ack_cycle", t_ack - t0, 1);
    check("vec_ack_onehot", bus.req_ack, 64'd1 << v.client);
    check("vec_fpu_op", bus.fpu_op, v.op);
    check("vec_fpu_opa", bus.fpu_opa, v.opa);
    check("vec_fpu_opb", bus.fpu_opb, v.opb);
    en_cnt = 0;
    early  = 1'b0;
    while (bus.fpu_en && en_cnt < 30) begin
      en_cnt++;
      tick();
      if (bus.rsp_valid != '0) early = 1'b1;
    end
    check("vec_en_cycles", en_cnt, EH);
    check("vec_no_early_rsp", early, 1'b0);
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.rsp_valid != '0) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    check("vec_rsp_seen", got, 1'b1);
    check("vec_rsp_latency", cyc - t_ack, v.exp_lat);
    check("vec_rsp_onehot", bus.rsp_valid, 64'd1 << v.client);
    check("vec_rsp_data", bus.rsp_data, v.exp_data);
    check("vec_rsp_err", bus.rsp_err, 1'b0);
    check("vec_opa_held", bus.fpu_opa, v.opa);
    tick();
    check("vec_rsp_pulse", bus.rsp_valid, 0);
    check("vec_data_held", bus.rsp_data, v.exp_data);
    check("vec_idle", bus.busy, 1'b0);
  endtask

  // Issue several requests at once; grants must follow grant_exp_q.
  task automatic run_burst(input logic [3:0] mask, input int exp_spacing);
    int n_grants, n_rsp, last_ack, g;
    n_grants = grant_exp_q.size();
    n_rsp    = 0;
    last_ack = -1;
    bus.req_valid = mask;
    for (int i = 0; i < 300 && n_rsp < n_grants; i++) begin
      tick();
      if (bus.rsp_valid != '0) begin
        if (exp_cl_q.size() == 0) begin
          check("burst_rsp_unexpected", bus.rsp_valid, 0);
        end else begin
          check("burst_rsp_client", bus.rsp_valid, exp_cl_q.pop_front());
          check("burst_rsp_data", bus.rsp_data, exp_q.pop_front());
        end
        n_rsp++;
      end
      if (bus.req_ack != '0) begin
        if (grant_exp_q.size() == 0) begin
          check("burst_ack_unexpected", bus.req_ack, 0);
        end else begin
          g = grant_exp_q.pop_front();
          check("burst_ack_client", bus.req_ack, 64'd1 << g);
          if (last_ack >= 0) check("burst_ack_spacing", cyc - last_ack, exp_spacing);
          last_ack = cyc;
          exp_q.push_back(cl_exp[g]);
          exp_cl_q.push_back(4'(1) << g);
        end
        bus.req_valid = bus.req_valid & ~bus.req_ack;
      end
    end
    check("burst_all_responses", n_rsp, n_grants);
    bus.req_valid = '0;
    exp_q.delete();
    exp_cl_q.delete();
    grant_exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic got;
    logic quiet;
    int   t_ack;

    vecs[0] = '{1, 3'b010, F_2, F_3, 3, 10, F_6};
    vecs[1] = '{3, 3'b011, F_8, F_2, 1, 8, F_4};
    vecs[2] = '{0, 3'b000, F_1, F_2, 2, 9, F_3};
    vecs[3] = '{2, 3'b001, F_5, F_1, 5, 12, F_4};
    vecs[4] = '{1, 3'b101, 64'h0123_4567_89AB_CDEF, 64'hFFFF_0000_FFFF_0000, 1, 8,
                64'hFEDC_4567_7654_CDEF};

    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_opa   = '0;
    bus.req_opb   = '0;
    bus.fpu_ready = 1'b0;

    // Reset values
    do_reset();
    check("rst_ack", bus.req_ack, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    check("rst_rsp_err", bus.rsp_err, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_fpu_en", bus.fpu_en, 1'b0);
    check("rst_fpu_op", bus.fpu_op, 0);
    check("rst_fpu_opa", bus.fpu_opa, 0);
    check("rst_fpu_opb", bus.fpu_opb, 0);
    check("rst_rmode", bus.fpu_rmode, 0);
    check("rst_state", bus.dbg_state, 0);

    // All four clients at once: round-robin from client 0
    rdy_mode  = 0;
    rdy_delay = 2;
    set_req(0, 3'b000, F_1, F_2);  cl_exp[0] = F_3;
    set_req(1, 3'b010, F_2, F_3);  cl_exp[1] = F_6;
    set_req(2, 3'b001, F_5, F_1);  cl_exp[2] = F_4;
    set_req(3, 3'b011, F_1, F_4);  cl_exp[3] = F_0P25;
    grant_exp_q = '{0, 1, 2, 3};
    run_burst(4'b1111, EH + 3);

    // Single-operation vector table
    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Stale ready held through S_ISSUE
    rdy_mode = 1;
    set_req(2, 3'b000, F_1, F_2);
    bus.req_valid = 4'b0100;
    wait_ack(got, t_ack);
    quiet = 1'b1;
    for (int i = 0; i < EH; i++) begin
      tick();
      if (bus.rsp_valid != '0) quiet = 1'b0;
    end
    check("stale_no_rsp_in_issue", quiet, 1'b1);
    check("stale_wait_state", bus.dbg_state, 2);
    tick();
    check("stale_rsp_latency", cyc - t_ack, EH + 1);
    check("stale_rsp_onehot", bus.rsp_valid, 4'b0100);
    check("stale_rsp_data", bus.rsp_data, F_3);
    tick();

    // Reset while in S_WAIT drops the operation
    rdy_mode = 2;
    set_req(1, 3'b010, F_2, F_3);
    bus.req_valid = 4'b0010;
    wait_ack(got, t_ack);
    repeat (EH + 2) tick();
    check("rstw_in_wait", bus.dbg_state, 2);
    rst = 1'b1;
    rdy_mode = 1;
    tick();
    rst = 1'b0;
    check("rstw_fpu_en", bus.fpu_en, 1'b0);
    check("rstw_busy", bus.busy, 1'b0);
    quiet = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (bus.rsp_valid != '0) quiet = 1'b0;
      tick();
    end
    check("rstw_no_rsp", quiet, 1'b1);

    // Reset while in S_ISSUE forces fpu_en low next cycle
    rdy_mode = 2;
    set_req(3, 3'b000, F_1, F_1);
    bus.req_valid = 4'b1000;
    wait_ack(got, t_ack);
    tick();
    tick();
    check("rsti_en_before", bus.fpu_en, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rsti_fpu_en", bus.fpu_en, 1'b0);
    check("rsti_state", bus.dbg_state, 0);

    // After reset client 0 wins over client 2
    rdy_mode  = 0;
    rdy_delay = 1;
    set_req(0, 3'b000, F_1, F_2);  cl_exp[0] = F_3;
    set_req(2, 3'b010, F_2, F_3);  cl_exp[2] = F_6;
    grant_exp_q = '{0, 2};
    run_burst(4'b0101, EH + 2);

    // FPU never becomes ready
    rdy_mode = 2;
    set_req(3, 3'b000, F_1, F_2);
    bus.req_valid = 4'b1000;
    wait_ack(got, t_ack);
    repeat (EH) tick();
    check("to_wait_entry", bus.dbg_state, 2);
`ifdef FPU_ARB_TIMEOUT_EN
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (bus.rsp_valid != '0) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    check("to_rsp_seen", got, 1'b1);
    check("to_rsp_latency", cyc - t_ack, EH + TO);
    check("to_rsp_onehot", bus.rsp_valid, 4'b1000);
    check("to_rsp_data", bus.rsp_data, 64'h7FF8_0000_0000_0000);
    check("to_rsp_err", bus.rsp_err, 1'b1);
    tick();
    check("to_err_pulse", bus.rsp_err, 1'b0);
    check("to_idle", bus.busy, 1'b0);
`else
    quiet = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (bus.rsp_valid != '0 || !bus.busy || bus.rsp_err) quiet = 1'b0;
    end
    check("noto_busy_no_rsp", quiet, 1'b1);
    check("noto_still_wait", bus.dbg_state, 2);
`endif
    do_reset();
    check("final_idle", bus.busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
